// File: rtl/pwm_speed_ramp_if.sv
// Target-speed command channel into the PWM speed ramp: valid/ready handshake
// carrying an 8-bit requested speed.
interface pwm_speed_ramp_if;
  localparam int unsigned SPEED_W = 8;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [SPEED_W-1:0] cmd_speed;

  modport master (output cmd_valid, output cmd_speed, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_speed, output cmd_ready);
endinterface

// File: rtl/pwm_speed_ramp.sv
// Slew-rate limiter feeding the PWM speed generator: clamps accepted targets
// and walks speed_out toward them by STEP once per tick, with emergency stop.
module pwm_speed_ramp #(
  parameter int unsigned TICK_DIV  = 607,
  parameter int unsigned STEP      = 4,
  parameter int unsigned MAX_SPEED = 199
) (
  input  logic                   clk,
  input  logic                   rst,
  pwm_speed_ramp_if.slave        cmd,
  input  logic                   estop,
  output logic [7:0]             speed_out,
  output logic                   at_target,
  output logic                   busy
);
  localparam int unsigned SPEED_W = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SUM_W   = SPEED_W + 1;

  typedef enum logic [1:0] {IDLE, UP, DOWN, STOP} state_t;

  state_t             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic               accept;
  logic [SPEED_W-1:0] clamped;
  logic [SUM_W-1:0]   up_sum;
  logic signed [SUM_W-1:0] dn_diff;

  assign tick          = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign cmd.cmd_ready = !rst && !estop && (state_q != STOP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign clamped       = (cmd.cmd_speed > SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                               : cmd.cmd_speed;
  // Step arithmetic one bit wider so neither direction can wrap.
  assign up_sum        = {1'b0, speed_q} + SUM_W'(STEP);
  assign dn_diff       = $signed({1'b0, speed_q}) - $signed(SUM_W'(STEP));

  assign speed_out = speed_q;
  assign at_target = (state_q == IDLE);
  assign busy      = (state_q == UP) || (state_q == DOWN);

  // State register, free-running tick counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      speed_q  <= '0;
      target_q <= '0;
      tick_cnt <= '0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      target_q <= target_d;
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  // Next state, target capture and per-tick step.
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    target_d = target_q;

    if (estop) begin
      state_d  = STOP;
      speed_d  = '0;
      target_d = '0;
    end else begin
      if (state_q == STOP)          state_d = IDLE;
      else if (speed_q < target_q)  state_d = UP;
      else if (speed_q > target_q)  state_d = DOWN;
      else                          state_d = IDLE;

      if (accept) target_d = clamped;

      if (tick && (state_q == UP)) begin
        speed_d = (up_sum > {1'b0, target_q}) ? target_q : up_sum[SPEED_W-1:0];
      end else if (tick && (state_q == DOWN)) begin
        speed_d = (dn_diff < $signed({1'b0, target_q})) ? target_q
                                                         : dn_diff[SPEED_W-1:0];
      end
    end
  end
endmodule
